// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Fetch sequencer states: issue a request, wait for its response,
    // hold a response in the skid buffer while decode is stalled.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    // addi x0, x0, 0 - presented to decode while nothing valid is held
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_buf
// Description : One-entry {insn, pc} holding register used when a memory
//               response returns while the decode output is still occupied.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_insn,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    output logic [XLEN-1:0] o_insn,
    output logic [XLEN-1:0] o_pc
);

    logic            r_valid;
    logic [XLEN-1:0] r_insn;
    logic [XLEN-1:0] r_pc;

    // Entry register; clear wins over load so a flush can never be overridden.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_insn  <= XLEN'(NOP_INSN);
            r_pc    <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_insn  <= i_insn;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_insn  = r_insn;
    assign o_pc    = r_pc;

endmodule : fetch_skid_buf
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Holds the PC, issues one request at
//               a time to instruction memory and presents {insn, pc} to
//               decode over valid/ready. Redirects from execute flush work.
//               Optional macro FETCH_MISALIGN_CHK_EN: a misaligned redirect
//               raises a sticky misalign_err and halts fetching.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_insn,
    output logic [XLEN-1:0] id_pc,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_pc,
    output logic            misalign_err
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inflight_pc;
    logic            r_discard;
    logic            w_discard_next;
    logic            r_id_valid;
    logic [XLEN-1:0] r_id_insn;
    logic [XLEN-1:0] r_id_pc;

    logic            w_req;
    logic            w_gnt;
    logic            w_redir;
    logic [XLEN-1:0] w_redir_pc;
    logic            w_halt;
    logic            w_out_load;
    logic            w_skid_load;
    logic            w_skid_pop;
    logic            w_skid_valid;
    logic [XLEN-1:0] w_skid_insn;
    logic [XLEN-1:0] w_skid_pc;

`ifdef FETCH_MISALIGN_CHK_EN
    logic r_misalign;
    logic w_misalign;

    // Once halted, further redirects are ignored.
    assign w_redir    = redir_valid && !r_misalign;
    assign w_misalign = w_redir && (redir_pc[1:0] != 2'b00);
    assign w_redir_pc = redir_pc;
    assign w_halt     = r_misalign;

    // Sticky error flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else if (w_misalign) begin
            r_misalign <= 1'b1;
        end
    end

    assign misalign_err = r_misalign;
`else
    // Low address bits of a redirect are dropped so fetch stays word aligned.
    assign w_redir      = redir_valid;
    assign w_redir_pc   = redir_pc & ~XLEN'(3);
    assign w_halt       = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // Request is gated by rst_n so nothing is issued while reset is held.
    assign w_req     = (r_state == REQ) && rst_n && !w_halt;
    assign w_gnt     = w_req && imem_gnt;
    assign imem_req  = w_req;
    assign imem_addr = r_pc;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= REQ;
            r_discard <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_discard <= w_discard_next;
        end
    end

    // Next state, discard tracking and datapath steering; redirect has priority.
    always_comb begin
        w_state_next   = r_state;
        w_discard_next = r_discard;
        w_out_load     = 1'b0;
        w_skid_load    = 1'b0;
        w_skid_pop     = 1'b0;
        if (w_redir) begin
            case (r_state)
                REQ: begin
                    if (w_gnt) begin
                        w_state_next   = WAIT;
                        w_discard_next = 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        w_state_next   = REQ;
                        w_discard_next = 1'b0;
                    end else begin
                        w_discard_next = 1'b1;
                    end
                end
                default: w_state_next = REQ;
            endcase
        end else begin
            case (r_state)
                REQ: begin
                    if (w_gnt) begin
                        w_state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        w_state_next = REQ;
                        if (r_discard) begin
                            w_discard_next = 1'b0;
                        end else if (!r_id_valid || id_ready) begin
                            w_out_load = 1'b1;
                        end else begin
                            w_skid_load  = 1'b1;
                            w_state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (id_ready && w_skid_valid) begin
                        w_skid_pop   = 1'b1;
                        w_state_next = REQ;
                    end
                end
                default: w_state_next = REQ;
            endcase
        end
    end

    // Program counter and the address of the request currently in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_inflight_pc <= '0;
        end else begin
            if (w_redir) begin
                r_pc <= w_redir_pc;
            end else if (w_gnt) begin
                r_pc <= r_pc + XLEN'(PC_STEP);
            end
            if (w_gnt) begin
                r_inflight_pc <= r_pc;
            end
        end
    end

    // Decode-facing output register: flush, refill from memory or skid, or drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_valid <= 1'b0;
            r_id_insn  <= XLEN'(NOP_INSN);
            r_id_pc    <= '0;
        end else if (w_redir) begin
            r_id_valid <= 1'b0;
        end else if (w_out_load) begin
            r_id_valid <= 1'b1;
            r_id_insn  <= imem_rdata;
            r_id_pc    <= r_inflight_pc;
        end else if (w_skid_pop) begin
            r_id_valid <= 1'b1;
            r_id_insn  <= w_skid_insn;
            r_id_pc    <= w_skid_pc;
        end else if (r_id_valid && id_ready) begin
            r_id_valid <= 1'b0;
        end
    end

    assign id_valid = r_id_valid;
    assign id_insn  = r_id_insn;
    assign id_pc    = r_id_pc;

    fetch_skid_buf #(
        .XLEN (XLEN)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_clear (w_redir || w_skid_pop),
        .i_insn  (imem_rdata),
        .i_pc    (r_inflight_pc),
        .o_valid (w_skid_valid),
        .o_insn  (w_skid_insn),
        .o_pc    (w_skid_pc)
    );

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard testbench for fetch_unit with a small instruction
//               memory model that grants a bounded number of requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_insn;
    logic [31:0] id_pc;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        misalign_err;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   budget = 0;
    int   lat    = 1;
    logic busy   = 1'b0;

    always #5 clk = ~clk;

    assign imem_gnt = (budget > 0) && !busy;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_insn      (id_insn),
        .id_pc        (id_pc),
        .redir_valid  (redir_valid),
        .redir_pc     (redir_pc),
        .misalign_err (misalign_err)
    );

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        q.push_back({insn_of(pc), pc});
    endtask

    // Memory model: one outstanding request, response 'lat' cycles after grant.
    initial begin
        logic [31:0] maddr;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (imem_req && imem_gnt) begin
                maddr = imem_addr;
                @(posedge clk);
                #1;
                budget = budget - 1;
                busy   = 1'b1;
                for (int k = 1; k < lat; k++) begin
                    @(posedge clk);
                    #1;
                end
                imem_rvalid = 1'b1;
                imem_rdata  = insn_of(maddr);
                @(posedge clk);
                #1;
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
                busy        = 1'b0;
            end
        end
    end

    // Monitor: pop and compare each instruction decode accepts.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (imem_req && imem_gnt)
                    chk("imem_addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
                if (id_valid && id_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got pc=%h insn=%h, required no output", id_pc, id_insn);
                    end else begin
                        e = q.pop_front();
                        chk("id_pc", id_pc, e.pc);
                        chk("id_insn", id_insn, e.insn);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        redir_valid = 1'b0;
        id_ready    = 1'b0;
        budget      = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            @(posedge clk);
            #2;
        end
        @(posedge clk);
        #1;
        q.delete();
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) begin
                got = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, got}, 32'd1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
        chk(name, q.size(), 32'd0);
        q.delete();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        id_ready    = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = '0;

        // 1: reset state, then a steady stream of sequential fetches
        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_insn", id_insn, 32'h0000_0013);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
        lat      = 2;
        budget   = 4;
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) expect_fetch(32'(i * 4));
        release_rst();
        drain("t1_stream");
        chk("t1_next_addr", imem_addr, 32'h10);
        chk("t1_next_req", {31'd0, imem_req}, 32'd1);

        // 2: decode stall parks a response in the skid buffer
        do_reset();
        lat      = 1;
        budget   = 3;
        id_ready = 1'b0;
        expect_fetch(32'h0);
        expect_fetch(32'h4);
        expect_fetch(32'h8);
        release_rst();
        repeat (8) @(negedge clk);
        chk("t2_hold_req", {31'd0, imem_req}, 32'd0);
        chk("t2_hold_valid", {31'd0, id_valid}, 32'd1);
        chk("t2_hold_pc", id_pc, 32'h0);
        @(posedge clk);
        #1;
        id_ready = 1'b1;
        drain("t2_order");

        // 3: redirect while waiting; late response must be dropped
        do_reset();
        lat      = 3;
        budget   = 2;
        id_ready = 1'b1;
        expect_fetch(32'h100);
        release_rst();
        wait_grant("t3_grant");
        chk("t3_first_addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        redir_valid = 1'b1;
        redir_pc    = 32'h100;
        @(posedge clk);
        #1;
        redir_valid = 1'b0;
        drain("t3_redirect");
        chk("t3_next_addr", imem_addr, 32'h104);

        // 4: redirect coincident with a grant
        do_reset();
        lat      = 1;
        budget   = 2;
        id_ready = 1'b1;
        expect_fetch(32'h200);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        redir_valid = 1'b1;
        redir_pc    = 32'h200;
        @(negedge clk);
        chk("t4_coincident_gnt", {31'd0, imem_req && imem_gnt}, 32'd1);
        @(posedge clk);
        #1;
        redir_valid = 1'b0;
        drain("t4_redirect");
        chk("t4_next_addr", imem_addr, 32'h204);

        // 5a: PC wraps from the top of the address space
        do_reset();
        lat      = 1;
        budget   = 0;
        id_ready = 1'b1;
        expect_fetch(32'hFFFF_FFFC);
        expect_fetch(32'h0);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        redir_valid = 1'b1;
        redir_pc    = 32'hFFFF_FFFC;
        @(posedge clk);
        #1;
        redir_valid = 1'b0;
        budget      = 2;
        @(negedge clk);
        chk("t5_top_addr", imem_addr, 32'hFFFF_FFFC);
        drain("t5_wrap");
        chk("t5_wrap_addr", imem_addr, 32'h4);

        // 5b: reset pulse while a response is outstanding
        do_reset();
        lat      = 3;
        budget   = 1;
        id_ready = 1'b1;
        release_rst();
        wait_grant("t5b_grant");
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        budget = 0;
        #1;
        chk("t5b_rst_valid", {31'd0, id_valid}, 32'd0);
        chk("t5b_rst_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        q.delete();
        rst_n  = 1'b1;
        budget = 2;
        expect_fetch(32'h0);
        expect_fetch(32'h4);
        wait_grant("t5b_regrant");
        chk("t5b_restart_addr", imem_addr, 32'h0);
        drain("t5b_after_reset");

        // 6: misaligned redirect
        do_reset();
        lat      = 1;
        budget   = 0;
        id_ready = 1'b1;
`ifndef FETCH_MISALIGN_CHK_EN
        expect_fetch(32'h100);
        expect_fetch(32'h104);
`endif
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        redir_valid = 1'b1;
        redir_pc    = 32'h102;
        @(posedge clk);
        #1;
        redir_valid = 1'b0;
        budget      = 2;
`ifdef FETCH_MISALIGN_CHK_EN
        repeat (5) @(negedge clk);
        chk("t6_misalign_err", {31'd0, misalign_err}, 32'd1);
        chk("t6_halt_req", {31'd0, imem_req}, 32'd0);
        chk("t6_halt_valid", {31'd0, id_valid}, 32'd0);
        @(posedge clk);
        #1;
        redir_valid = 1'b1;
        redir_pc    = 32'h200;
        @(posedge clk);
        #1;
        redir_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_ignore_redir", {31'd0, imem_req}, 32'd0);
        chk("t6_err_sticky", {31'd0, misalign_err}, 32'd1);
`else
        drain("t6_aligned_fetch");
        chk("t6_misalign_err", {31'd0, misalign_err}, 32'd0);
        chk("t6_next_addr", imem_addr, 32'h108);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
